video_timing_gen: RTL and testbench

- Generates raster timing for the HDMI output path, running in the pixel clock domain.
- Produces pixel coordinates (x, y) for the game-of-life renderer, plus hsync/vsync/de for the TMDS encoder, all aligned in the same cycle.
- Also emits frame-rate strobes, so the board update can be tied to vertical blanking instead of a free-running delay counter.
- Default timing is 640x480@60 (25.175 MHz pixel clock).

---
 rtl/video_timing_gen.sv | 117 +++++++++++
 tb/tb_video_timing_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator for the HDMI output path (pixel clock domain).
// Stage 0 holds the free-running horizontal/vertical counters; stage 1
// registers every output from those counters so that coordinates, syncs,
// data enable and frame strobes always describe the same pixel.
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic       pxl_clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       vblank_tick,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_too_large
      $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  // Boundaries are held one bit wider than the counters so a sync or porch
  // edge that lands exactly on 1024 still compares correctly.
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SS   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SS   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SE   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;
  logic [10:0] hc_w, vc_w;
  logic        started_q;
  logic        de_d, hsync_d, vsync_d, fs_d, vt_d;
  logic [7:0]  fc_d;

  assign hc_w = {1'b0, hc_q};
  assign vc_w = {1'b0, vc_q};

  // Next counter values: hc wraps each line, vc advances/wraps on hc wrap.
  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_w == H_LAST) begin
      hc_d = '0;
      if (vc_w == V_LAST) vc_d = '0;
      else                vc_d = vc_q + 10'd1;
    end
  end

  // Decode of the current counter position into next output values.
  always_comb begin
    de_d    = (hc_w < H_ACT) && (vc_w < V_ACT);
    hsync_d = (hc_w >= H_SS && hc_w < H_SE) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = (vc_w >= V_SS && vc_w < V_SE) ? VSYNC_POL : ~VSYNC_POL;
    fs_d    = (hc_q == 10'd0) && (vc_q == 10'd0);
    vt_d    = (hc_q == 10'd0) && (vc_w == V_ACT);
    // The first frame_start after reset opens a frame rather than closing one.
    fc_d    = (fs_d && started_q) ? frame_count + 8'd1 : frame_count;
  end

  // ---- stage 0: raster counters ----
  always_ff @(posedge pxl_clk or posedge rst) begin
    if (rst) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  // ---- stage 1: registered outputs, one cycle behind the counters ----
  always_ff @(posedge pxl_clk or posedge rst) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      frame_start <= 1'b0;
      vblank_tick <= 1'b0;
      frame_count <= '0;
      started_q   <= 1'b0;
    end else begin
      x           <= hc_q;
      y           <= vc_q;
      de          <= de_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      frame_start <= fs_d;
      vblank_tick <= vt_d;
      frame_count <= fc_d;
      started_q   <= started_q | fs_d;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default 640x480 instance and a tiny
// 16x7 instance with active-high syncs share one clock. A reference model
// pushes the expected output word each rising edge; the monitor pops and
// compares it on the falling edge. Directed checks cover reset, release,
// asynchronous reset, line/frame shape and frame_count wrap.
`timescale 1ns/1ps
module tb_video_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       vt;
    logic [7:0] fc;
  } out_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, sel;
  logic mrst;

  logic [9:0] xa, ya, xb, yb;
  logic       dea, hsa, vsa, fsa, vta, deb, hsb, vsb, fsb, vtb;
  logic [7:0] fca, fcb;
  out_t       got_a, got_b, got;

  int n_chk  = 0;
  int n_pass = 0;

  // Model parameters for whichever instance is currently observed.
  int   hA, hF, hS, hB, vA, vF, vS, vB;
  logic hp, vp;

  int         m_hc, m_vc;
  logic       m_started;
  logic [7:0] m_fc;
  out_t       sbq[$];

  video_timing_gen dut_a (
    .pxl_clk(clk), .rst(rst_a), .x(xa), .y(ya), .de(dea), .hsync(hsa),
    .vsync(vsa), .frame_start(fsa), .vblank_tick(vta), .frame_count(fca)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_b (
    .pxl_clk(clk), .rst(rst_b), .x(xb), .y(yb), .de(deb), .hsync(hsb),
    .vsync(vsb), .frame_start(fsb), .vblank_tick(vtb), .frame_count(fcb)
  );

  assign got_a = {xa, ya, dea, hsa, vsa, fsa, vta, fca};
  assign got_b = {xb, yb, deb, hsb, vsb, fsb, vtb, fcb};
  assign got   = sel ? got_b : got_a;
  assign mrst  = sel ? rst_b : rst_a;

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic out_t model_out(int hc, int vc);
    out_t e;
    e.x  = 10'(hc);
    e.y  = 10'(vc);
    e.de = (hc < hA) && (vc < vA);
    e.hs = (hc >= hA + hF && hc < hA + hF + hS) ? hp : ~hp;
    e.vs = (vc >= vA + vF && vc < vA + vF + vS) ? vp : ~vp;
    e.fs = (hc == 0) && (vc == 0);
    e.vt = (hc == 0) && (vc == vA);
    e.fc = 8'd0;
    return e;
  endfunction

  // Reference model: expected output for the edge just taken.
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      if (mrst) begin
        m_hc = 0; m_vc = 0; m_started = 1'b0; m_fc = 8'd0;
        sbq.delete();
      end else begin
        e = model_out(m_hc, m_vc);
        if (e.fs) begin
          if (m_started) m_fc = m_fc + 8'd1;
          m_started = 1'b1;
        end
        e.fc = m_fc;
        sbq.push_back(e);
        m_hc++;
        if (m_hc == hA + hF + hS + hB) begin
          m_hc = 0;
          m_vc++;
          if (m_vc == vA + vF + vS + vB) m_vc = 0;
        end
      end
    end
  end

  // Monitor: compare the observed instance against the scoreboard.
  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("sb", 64'(got), 64'(e));
      end
    end
  end

  initial begin
    out_t rst_exp_a, rst_exp_b, first_exp, second_exp, g;
    int de_cnt, hs_cnt, hs_first, hs_last, de_last;
    int nfs, cyc, last_fs, bad_per, bad_fc;
    logic [7:0] prev_fc;
    int f_de, f_hs, f_hs_xmin, f_hs_xmax, f_vs, f_vs_ymin, f_vs_ymax, f_vt, f_vt_x, f_vt_y;

    hA = 640; hF = 16; hS = 96; hB = 48; vA = 480; vF = 10; vS = 2; vB = 33;
    hp = 1'b0; vp = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0;

    rst_exp_a = '0; rst_exp_a.hs = 1'b1; rst_exp_a.vs = 1'b1;
    rst_exp_b = '0;
    first_exp = rst_exp_a; first_exp.de = 1'b1; first_exp.fs = 1'b1;
    second_exp = first_exp; second_exp.x = 10'd1; second_exp.fs = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_a", 64'(got_a), 64'(rst_exp_a));
    rst_a = 1'b0;
    @(posedge clk); #1;
    check("release_c1", 64'(got_a), 64'(first_exp));
    @(posedge clk); #1;
    check("release_c2", 64'(got_a), 64'(second_exp));

    // One full line starting at x=0, y=1.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (xa == 10'd0 && ya == 10'd1) break;
    end
    check("line_start", {xa, ya}, {10'd0, 10'd1});
    de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; de_last = -1;
    for (int i = 0; i < 800; i++) begin
      if (dea) begin de_cnt++; de_last = int'(xa); end
      if (!hsa) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(xa);
        hs_last = int'(xa);
      end
      @(negedge clk);
    end
    check("line_wrap", {xa, ya}, {10'd0, 10'd2});
    check("de_count", 64'(de_cnt), 64'd640);
    check("de_last_x", 64'(de_last), 64'd639);
    check("hs_count", 64'(hs_cnt), 64'd96);
    check("hs_first_x", 64'(hs_first), 64'd656);
    check("hs_last_x", 64'(hs_last), 64'd751);

    // Asynchronous reset mid-line.
    for (int i = 0; i < 1000; i++) begin
      if (xa == 10'd300 && ya == 10'd2) break;
      @(negedge clk);
    end
    check("pre_rst_pos", {xa, ya}, {10'd300, 10'd2});
    #2 rst_a = 1'b1;
    #1 check("async_rst", 64'(got_a), 64'(rst_exp_a));
    repeat (3) @(negedge clk);
    check("held_rst", 64'(got_a), 64'(rst_exp_a));
    rst_a = 1'b0;
    @(posedge clk); #1;
    check("rerelease_c1", 64'(got_a), 64'(first_exp));
    @(posedge clk); #1;
    check("rerelease_c2", 64'(got_a), 64'(second_exp));

    // Switch to the small-timing instance.
    @(negedge clk); #2;
    rst_a = 1'b1; sel = 1'b1;
    hA = 8; hF = 2; hS = 3; hB = 3; vA = 4; vF = 1; vS = 1; vB = 1;
    hp = 1'b1; vp = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_b", 64'(got_b), 64'(rst_exp_b));
    rst_b = 1'b0;

    nfs = 0; cyc = 0; last_fs = 0; bad_per = 0; bad_fc = 0; prev_fc = 8'd0;
    f_de = 0; f_hs = 0; f_hs_xmin = 1023; f_hs_xmax = 0;
    f_vs = 0; f_vs_ymin = 1023; f_vs_ymax = 0; f_vt = 0; f_vt_x = -1; f_vt_y = -1;
    for (int i = 0; i < 16 * 7 * 260; i++) begin
      @(negedge clk);
      cyc++;
      g = got_b;
      if (g.fc != prev_fc && !g.fs) bad_fc++;
      prev_fc = g.fc;
      if (g.fs) begin
        nfs++;
        if (nfs > 1 && cyc - last_fs != 112) bad_per++;
        last_fs = cyc;
        if (nfs == 256) check("fc_255", 64'(g.fc), 64'd255);
        if (nfs == 257) begin
          check("fc_wrap", 64'(g.fc), 64'd0);
          break;
        end
      end
      if (nfs == 1) begin
        if (g.de) f_de++;
        if (g.hs) begin
          f_hs++;
          if (int'(g.x) < f_hs_xmin) f_hs_xmin = int'(g.x);
          if (int'(g.x) > f_hs_xmax) f_hs_xmax = int'(g.x);
        end
        if (g.vs) begin
          f_vs++;
          if (int'(g.y) < f_vs_ymin) f_vs_ymin = int'(g.y);
          if (int'(g.y) > f_vs_ymax) f_vs_ymax = int'(g.y);
        end
        if (g.vt) begin f_vt++; f_vt_x = int'(g.x); f_vt_y = int'(g.y); end
      end
    end
    check("frames_seen", 64'(nfs), 64'd257);
    check("fs_period", 64'(bad_per), 64'd0);
    check("fc_only_on_fs", 64'(bad_fc), 64'd0);
    check("small_de_frame", 64'(f_de), 64'd32);
    check("small_hs_count", 64'(f_hs), 64'd21);
    check("small_hs_xrange", {32'(f_hs_xmin), 32'(f_hs_xmax)}, {32'd10, 32'd12});
    check("small_vs_count", 64'(f_vs), 64'd16);
    check("small_vs_yrange", {32'(f_vs_ymin), 32'(f_vs_ymax)}, {32'd5, 32'd5});
    check("small_vt_count", 64'(f_vt), 64'd1);
    check("small_vt_pos", {32'(f_vt_x), 32'(f_vt_y)}, {32'd0, 32'd4});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
